// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage access controller between the EX/MEM register
// and a level-handshake data memory. Freezes the pipeline while an access is
// outstanding, captures load data for MEM/WB, and flags misaligned requests
// and memory timeouts without hanging the pipeline.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        mem_enable_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter value in the last ACCESS cycle allowed before abort.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;

    logic req;
    logic aligned;
    logic start;
    logic ack_hit;
    logic timeout_hit;

    assign req         = MemRead_i | MemWrite_i;
    assign aligned     = (addr_i[1:0] == 2'b00);
    assign start       = (state_q == IDLE) & req & aligned;
    assign ack_hit     = (state_q == ACCESS) & mem_ack_i;
    // Ack takes priority: a timeout only fires in a cycle with no ack.
    assign timeout_hit = (state_q == ACCESS) & ~mem_ack_i & (cnt_q == TO_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DONE always returns to IDLE so the stale request
    // still sitting in EX/MEM is never re-issued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCESS;
            ACCESS:  if (ack_hit || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; stall is forced low while reset is held.
    always_comb begin
        stall_o      = rst_i & (start | (state_q == ACCESS));
        mem_enable_o = (state_q == ACCESS);
    end

    // Datapath next-state: request latch, wait counter, load data, pulses.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    write_d = MemWrite_i;   // read+write together counts as store
                    cnt_d   = 8'd0;
                end else if (req) begin
                    mis_d   = 1'b1;
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    if (!write_q) rdata_d = mem_data_i;
                end else if (timeout_hit) begin
                    if (!write_q) rdata_d = 32'd0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign data_o      = rdata_q;
    assign misalign_o  = mis_q;
    assign err_o       = err_q;
    assign mem_write_o = write_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a driver plays EX/MEM and memory and
// pushes the expected outcome of each request; a monitor pops and compares
// whenever the DUT completes an access or pulses misalign.
module tb_mem_stage_ctrl;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, data_i;
    logic        stall_o;
    logic [31:0] data_o;
    logic        misalign_o, err_o;
    logic        mem_enable_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .data_i(data_i),
        .stall_o(stall_o), .data_o(data_o),
        .misalign_o(misalign_o), .err_o(err_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          mis;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;   // data_o expected once this request retires
        bit          err;
        int          len;    // ACCESS cycles
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [31:0] model_data = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // op: 0 load, 1 store, 2 read+write (store). lat: ACCESS cycle carrying ack.
    task automatic drive_txn(input int op, input logic [31:0] a, input logic [31:0] d,
                             input int lat, input logic [31:0] rd);
        exp_t e;
        int   cyc;
        @(negedge clk_i);
        MemRead_i  = (op != 1);
        MemWrite_i = (op != 0);
        addr_i     = a;
        data_i     = d;
        mem_ack_i  = 1'b0;
        e.mis   = (a[1:0] != 2'b00);
        e.wr    = (op != 0);
        e.addr  = a;
        e.wdata = d;
        e.err   = 1'b0;
        e.len   = 0;
        if (!e.mis) begin
            if (lat <= TMO) begin
                e.len = lat;
                if (!e.wr) model_data = rd;
            end else begin
                e.len = TMO;
                e.err = 1'b1;
                if (!e.wr) model_data = 32'd0;
            end
        end
        e.data = model_data;
        sb.push_back(e);
        @(posedge clk_i);
        if (e.mis) return;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            if (!mem_enable_o) break;
            cyc++;
            if (cyc > 64) begin
                chk("access_bound", 32'(cyc), 32'd64);
                break;
            end
            mem_ack_i  = (cyc == lat);
            mem_data_i = (cyc == lat) ? rd : $urandom;
        end
        // DONE cycle: request still presented, stray ack must be ignored
        mem_ack_i  = 1'($urandom_range(0, 1));
        mem_data_i = $urandom;
        @(posedge clk_i);
    endtask

    task automatic gap();
        @(negedge clk_i);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        addr_i     = $urandom;
        mem_ack_i  = 1'($urandom_range(0, 1));
        mem_data_i = $urandom;
        @(posedge clk_i);
    endtask

    task automatic rand_txn();
        int          op;
        logic [31:0] a;
        op = $urandom_range(0, 2);
        a  = $urandom;
        if ($urandom_range(0, 6) != 0) a[1:0] = 2'b00;
        drive_txn(op, a, $urandom, $urandom_range(1, TMO + 2), $urandom);
        if ($urandom_range(0, 2) == 0) gap();
    endtask

    // Monitor: samples 2 time units after the falling edge.
    initial begin : monitor
        int   en_cnt;
        int   st_cnt;
        bit   prev_en;
        logic [31:0] cur;
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (!mon_en) begin
                en_cnt = 0; st_cnt = 0; prev_en = 1'b0; cur = 32'd0;
                continue;
            end
            if (prev_en && !mem_enable_o) begin
                if (sb.size() == 0) begin
                    chk("done_without_request", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind_misaligned", 32'(e.mis), 32'd0);
                    chk("enable_cycles", 32'(en_cnt), 32'(e.len));
                    chk("stall_cycles", 32'(st_cnt), 32'(e.len + 1));
                    chk("err_pulse", 32'(err_o), 32'(e.err));
                    cur = e.data;
                end
                en_cnt = 0; st_cnt = 0;
            end else begin
                chk("err_idle", 32'(err_o), 32'd0);
            end
            if (misalign_o) begin
                if (sb.size() == 0 || !sb[0].mis) begin
                    chk("unexpected_misalign", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("misalign_stall", 32'(st_cnt), 32'd0);
                    cur = e.data;
                end
                st_cnt = 0;
            end
            if (mem_enable_o) begin
                en_cnt++;
                chk("access_stall", 32'(stall_o), 32'd1);
                if (sb.size() == 0) begin
                    chk("access_without_request", 32'd1, 32'd0);
                end else begin
                    chk("mem_addr", mem_addr_o, sb[0].addr);
                    chk("mem_write", 32'(mem_write_o), 32'(sb[0].wr));
                    if (sb[0].wr) chk("mem_data", mem_data_o, sb[0].wdata);
                end
            end
            if (stall_o) st_cnt++;
            chk("data_o", data_o, cur);
            prev_en = mem_enable_o;
        end
    end

    initial begin : stim
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        addr_i = 32'd0; data_i = 32'd0; mem_ack_i = 1'b0; mem_data_i = 32'd0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_enable", 32'(mem_enable_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        chk("rst_write", 32'(mem_write_o), 32'd0);
        @(negedge clk_i);
        rst_i  = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        drive_txn(0, 32'h0000_0010, 32'h0, 3, 32'hCAFE_F00D);
        drive_txn(1, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_FFFF);
        drive_txn(0, 32'h0000_0013, 32'h0, 1, 32'h1111_1111);
        gap();
        drive_txn(0, 32'h0000_0044, 32'h0, 100, 32'h2222_2222);  // timeout
        gap();
        drive_txn(0, 32'h0000_0048, 32'h0, TMO, 32'h3333_3333);  // ack on last cycle
        drive_txn(1, 32'h0000_0050, 32'hA5A5_5A5A, 1, 32'h0);    // store then load
        drive_txn(0, 32'h0000_0050, 32'h0, 1, 32'hA5A5_5A5A);
        drive_txn(1, 32'h0000_0060, 32'h7777_7777, 100, 32'h0);  // store timeout
        drive_txn(2, 32'h0000_0064, 32'h8888_8888, 2, 32'h0);    // read+write

        for (int i = 0; i < 60; i++) rand_txn();
        gap();
        gap();

        // Reset in the 2nd ACCESS cycle of an unacknowledged load
        mon_en = 1'b0;
        @(negedge clk_i);
        MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h0000_0080;
        @(posedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_data", data_o, 32'd0);
        chk("midrst_misalign", 32'(misalign_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        chk("midrst_enable", 32'(mem_enable_o), 32'd0);
        chk("midrst_write", 32'(mem_write_o), 32'd0);
        chk("midrst_addr", mem_addr_o, 32'd0);
        chk("midrst_mem_data", mem_data_o, 32'd0);
        @(negedge clk_i);
        mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        mem_ack_i = 1'b0; MemRead_i = 1'b0; rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        chk("postrst_data", data_o, 32'd0);
        chk("postrst_enable", 32'(mem_enable_o), 32'd0);
        chk("postrst_stall", 32'(stall_o), 32'd0);
        model_data = 32'd0;
        mon_en = 1'b1;

        for (int i = 0; i < 15; i++) rand_txn();
        gap();
        gap();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
